// File: rtl/usb_bulk_stream_bridge.sv
// Bulk IN/OUT endpoint bridge between usb_fs_pe endpoint ports and byte streams.
// Buffers each direction, flushes short IN packets, terminates with ZLP, tracks host presence.

module usb_bulk_fifo #(
  parameter int DEPTH = 64,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic [LW-1:0] level_o,
  output logic          empty_o,
  output logic          full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

module usb_bulk_stream_bridge #(
  parameter int FIFO_DEPTH   = 64,
  parameter int MAX_PKT      = 32,
  parameter int FLUSH_CYCLES = 48000,
  parameter int HOST_TIMEOUT = 144000,
  parameter int ZLP_EN       = 1,
  localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_48mhz,
  input  logic          reset_n,
  input  logic          sof_valid,
  output logic          in_ep_req,
  input  logic          in_ep_grant,
  input  logic          in_ep_data_free,
  output logic          in_ep_data_put,
  output logic [7:0]    in_ep_data,
  output logic          in_ep_data_done,
  output logic          in_ep_stall,
  input  logic          in_ep_acked,
  output logic          out_ep_req,
  input  logic          out_ep_grant,
  input  logic          out_ep_data_avail,
  input  logic          out_ep_setup,
  output logic          out_ep_data_get,
  input  logic [7:0]    out_ep_data,
  output logic          out_ep_stall,
  input  logic          out_ep_acked,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          host_present,
  output logic [LW-1:0] in_level,
  output logic [LW-1:0] out_level
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int SW = $clog2(HOST_TIMEOUT + 1);
  localparam int CW = $clog2(MAX_PKT + 1);

  typedef enum logic [2:0] {IN_IDLE, IN_REQ, IN_FILL, IN_DONE, IN_WAIT_ACK} in_state_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_READ, OUT_DRAIN} out_state_e;

  in_state_e     in_state_q, in_state_d;
  out_state_e    out_state_q, out_state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic          zlp_pend_q, zlp_pend_d;
  logic [FW-1:0] flush_q;
  logic [SW-1:0] sof_timer_q;
  logic          host_present_q;
  logic          get_q;
  logic          launch;
  logic          flush_expired;
  logic          in_push, in_empty, in_full, out_empty, out_full;
  logic [7:0]    in_head, out_head;
  logic [LW-1:0] out_free;
  logic          unused_inputs;

  assign unused_inputs = out_ep_acked;
  assign in_ep_stall   = 1'b0;
  assign out_ep_stall  = 1'b0;
  assign host_present  = host_present_q;

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      sof_timer_q    <= '0;
      host_present_q <= 1'b0;
    end else if (sof_valid) begin
      sof_timer_q    <= '0;
      host_present_q <= 1'b1;
    end else if (sof_timer_q != SW'(HOST_TIMEOUT - 1)) begin
      sof_timer_q    <= sof_timer_q + 1'b1;
    end else begin
      host_present_q <= 1'b0;
    end
  end

  // Without a host the IN side is a byte sink: accept everything, keep nothing.
  assign in_ready = host_present_q ? !in_full : 1'b1;
  assign in_push  = in_valid && host_present_q && !in_full;

  usb_bulk_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_in_fifo (
    .clk     (clk_48mhz),
    .rst_n   (reset_n),
    .clr_i   (!host_present_q),
    .push_i  (in_push),
    .data_i  (in_data),
    .pop_i   (in_ep_data_put),
    .data_o  (in_head),
    .level_o (in_level),
    .empty_o (in_empty),
    .full_o  (in_full)
  );

  assign flush_expired = (flush_q == FW'(FLUSH_CYCLES));

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      flush_q <= '0;
    end else if (!host_present_q || in_push || launch) begin
      flush_q <= '0;
    end else if (in_state_q == IN_IDLE && (!in_empty || zlp_pend_q) && !flush_expired) begin
      flush_q <= flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      in_state_q <= IN_IDLE;
      in_cnt_q   <= '0;
      zlp_pend_q <= 1'b0;
    end else begin
      in_state_q <= in_state_d;
      in_cnt_q   <= in_cnt_d;
      zlp_pend_q <= zlp_pend_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    in_state_d      = in_state_q;
    in_cnt_d        = in_cnt_q;
    zlp_pend_d      = zlp_pend_q;
    in_ep_req       = 1'b0;
    in_ep_data_put  = 1'b0;
    in_ep_data_done = 1'b0;
    launch          = 1'b0;
    case (in_state_q)
      IN_IDLE: begin
        if (host_present_q && (in_level >= LW'(MAX_PKT) ||
                               (flush_expired && (!in_empty || zlp_pend_q)))) begin
          in_state_d = IN_REQ;
          in_cnt_d   = '0;
          launch     = 1'b1;
        end
      end
      IN_REQ: begin
        in_ep_req = 1'b1;
        if (in_ep_grant) in_state_d = IN_FILL;
      end
      IN_FILL: begin
        in_ep_req = 1'b1;
        if (in_cnt_q == CW'(MAX_PKT) || in_empty) begin
          in_state_d = IN_DONE;
        end else if (in_ep_data_free) begin
          in_ep_data_put = 1'b1;
          in_cnt_d       = in_cnt_q + 1'b1;
        end
      end
      IN_DONE: begin
        in_ep_req       = 1'b1;
        in_ep_data_done = 1'b1;
        // A full-size packet leaves the host expecting more; a ZLP ends the transfer.
        zlp_pend_d      = (ZLP_EN != 0) && (in_cnt_q == CW'(MAX_PKT));
        in_state_d      = IN_WAIT_ACK;
      end
      IN_WAIT_ACK: begin
        if (in_ep_acked) in_state_d = IN_IDLE;
      end
      default: in_state_d = IN_IDLE;
    endcase
    if (!host_present_q) begin
      in_state_d      = IN_IDLE;
      zlp_pend_d      = 1'b0;
      in_ep_req       = 1'b0;
      in_ep_data_put  = 1'b0;
      in_ep_data_done = 1'b0;
      launch          = 1'b0;
    end
  end

  assign in_ep_data = in_ep_data_put ? in_head : 8'h00;

  usb_bulk_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_out_fifo (
    .clk     (clk_48mhz),
    .rst_n   (reset_n),
    .clr_i   (1'b0),
    .push_i  (get_q),
    .data_i  (out_ep_data),
    .pop_i   (out_ready),
    .data_o  (out_head),
    .level_o (out_level),
    .empty_o (out_empty),
    .full_o  (out_full)
  );

  assign out_valid = !out_empty;
  assign out_data  = out_valid ? out_head : 8'h00;
  assign out_free  = LW'(FIFO_DEPTH) - out_level;

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      out_state_q <= OUT_IDLE;
      get_q       <= 1'b0;
    end else begin
      out_state_q <= out_state_d;
      get_q       <= out_ep_data_get && !out_full;
    end
  end

  // Only start a packet when a whole MAX_PKT fits; otherwise the PE NAKs the host for us.
  always_comb begin
    out_state_d     = out_state_q;
    out_ep_req      = 1'b0;
    out_ep_data_get = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        if (out_ep_data_avail && !out_ep_setup && out_free >= LW'(MAX_PKT))
          out_state_d = OUT_REQ;
      end
      OUT_REQ: begin
        out_ep_req = 1'b1;
        if (out_ep_grant) out_state_d = OUT_READ;
      end
      OUT_READ: begin
        out_ep_req = 1'b1;
        if (out_ep_data_avail) out_ep_data_get = 1'b1;
        else                   out_state_d     = OUT_DRAIN;
      end
      OUT_DRAIN: out_state_d = OUT_IDLE;
      default:   out_state_d = OUT_IDLE;
    endcase
  end
endmodule
